// File: rtl/matmul_sched.sv
// Job sequencer for the NxN systolic MAC array.
// Accepts one job per start, clears/loads the array, drives skewed row and
// column shift enables, waits for the pipeline to drain, then reports done.
// All outputs are registered and decoded from the next state and counter.
module matmul_sched #(
    parameter int N        = 8,
    parameter int PIPE_LAT = 2,
    parameter int CW       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         result_valid,
    output logic         load_en,
    output logic         acc_clr_n,
    output logic [N-1:0] shift_a,
    output logic [N-1:0] shift_b,
    output logic [15:0]  job_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Last counter value in RUN (2N-1 cycles) and DRAIN (N-1+PIPE_LAT cycles).
    localparam logic [CW-1:0] RUN_LAST   = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2 + PIPE_LAT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rv_q, rv_d;
    logic [15:0]   job_q, job_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_q, load_d;
    logic          clr_n_q, clr_n_d;
    logic [N-1:0]  shift_q, shift_d;

    // Next-state logic plus decode of the registered outputs from the next state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rv_d    = rv_q;
        job_d   = job_q;

        if (abort) begin
            // Abort wins everywhere, including over start in IDLE.
            state_d = S_IDLE;
            cnt_d   = '0;
            rv_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        rv_d    = 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
                S_RUN: begin
                    if (cnt_q == RUN_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    rv_d    = 1'b1;
                    job_d   = job_q + 16'd1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d  = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
        load_d  = (state_d == S_CLEAR);
        clr_n_d = (state_d != S_CLEAR);

        // Row/column i shifts for N cycles starting at RUN count i.
        shift_d = '0;
        for (int i = 0; i < N; i++) begin
            shift_d[i] = (state_d == S_RUN) && (int'(cnt_d) >= i) && (int'(cnt_d) < i + N);
        end
    end

    // State, counters and output registers; async reset puts everything idle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            job_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            clr_n_q <= 1'b1;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            job_q   <= job_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            clr_n_q <= clr_n_d;
            shift_q <= shift_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign load_en      = load_q;
    assign acc_clr_n    = clr_n_q;
    assign shift_a      = shift_q;
    assign shift_b      = shift_q;
    assign job_cnt      = job_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched. Expected outputs come from a
// job-relative timeline model; products come from a systolic array model
// driven by the scheduler and compared against a plain matrix multiply.
module tb_matmul_sched;

    localparam int N        = 8;
    localparam int PIPE_LAT = 2;
    localparam int CW       = 8;
    localparam int T_DONE   = 3 * N + PIPE_LAT;
    localparam int SPACING  = 3 * N + PIPE_LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic         load_en;
    logic         acc_clr_n;
    logic [N-1:0] shift_a;
    logic [N-1:0] shift_b;
    logic [15:0]  job_cnt;

    matmul_sched #(.N(N), .PIPE_LAT(PIPE_LAT), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .load_en      (load_en),
        .acc_clr_n    (acc_clr_n),
        .shift_a      (shift_a),
        .shift_b      (shift_b),
        .job_cnt      (job_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Timeline model: t = 0 idle, t = 1..T_DONE position inside the job.
    int          m_t;
    logic        m_rv;
    logic [15:0] m_jobs;

    // Array model state.
    int a_next [N][N];
    int b_next [N][N];
    int a_job  [N][N];
    int b_job  [N][N];
    int a_reg  [N][N];
    int b_reg  [N][N];
    int acc    [N][N];
    int ka     [N];
    int kb     [N];
    int sh_cnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic randomize_next();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_next[i][j] = int'($urandom_range(0, 255));
                b_next[i][j] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_rv   = 1'b0;
        m_jobs = 16'd0;
    endtask

    // Advance the timeline by one clock edge with the given inputs.
    task automatic model_edge(input logic s, input logic a);
        if (a) begin
            m_t  = 0;
            m_rv = 1'b0;
        end else if (m_t == 0) begin
            if (s) begin
                m_t  = 1;
                m_rv = 1'b0;
            end
        end else if (m_t == T_DONE) begin
            m_t    = 0;
            m_rv   = 1'b1;
            m_jobs = m_jobs + 16'd1;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_sh;
        int           k;
        k      = m_t - 2;
        exp_sh = '0;
        if (m_t >= 2 && m_t <= 2 * N)
            for (int i = 0; i < N; i++) exp_sh[i] = (k >= i) && (k < i + N);
        check("busy",         32'(busy),         32'(m_t >= 1 && m_t < T_DONE));
        check("done",         32'(done),         32'(m_t == T_DONE));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("load_en",      32'(load_en),      32'(m_t == 1));
        check("acc_clr_n",    32'(acc_clr_n),    32'(m_t != 1));
        check("shift_a",      32'(shift_a),      32'(exp_sh));
        check("shift_b",      32'(shift_b),      32'(exp_sh));
        check("job_cnt",      32'(job_cnt),      32'(m_jobs));
    endtask

    // One cycle of the systolic array, driven by the scheduler's outputs.
    task automatic array_step();
        int inj_a [N];
        int inj_b [N];
        int na, nb;
        if (!acc_clr_n) begin
            for (int i = 0; i < N; i++) begin
                ka[i] = 0;
                kb[i] = 0;
                sh_cnt[i] = 0;
                for (int j = 0; j < N; j++) begin
                    acc[i][j]   = 0;
                    a_reg[i][j] = 0;
                    b_reg[i][j] = 0;
                end
            end
        end
        if (load_en) begin
            a_job = a_next;
            b_job = b_next;
            randomize_next();
        end
        if (!acc_clr_n) return;
        for (int i = 0; i < N; i++) begin
            inj_a[i] = 0;
            inj_b[i] = 0;
            if (shift_a[i]) begin
                if (ka[i] < N) inj_a[i] = a_job[i][ka[i]];
                ka[i]++;
                sh_cnt[i]++;
            end
            if (shift_b[i]) begin
                if (kb[i] < N) inj_b[i] = b_job[kb[i]][i];
                kb[i]++;
            end
        end
        for (int i = N - 1; i >= 0; i--)
            for (int j = N - 1; j >= 0; j--) begin
                na = (j == 0) ? inj_a[i] : a_reg[i][j-1];
                nb = (i == 0) ? inj_b[j] : b_reg[i-1][j];
                acc[i][j]  += na * nb;
                a_reg[i][j] = na;
                b_reg[i][j] = nb;
            end
    endtask

    task automatic check_products();
        int ref_c;
        for (int i = 0; i < N; i++) begin
            check("shift_count", 32'(sh_cnt[i]), 32'(N));
            for (int j = 0; j < N; j++) begin
                ref_c = 0;
                for (int k = 0; k < N; k++) ref_c += a_job[i][k] * b_job[k][j];
                check("product", 32'(acc[i][j]), 32'(ref_c));
            end
        end
    endtask

    // Drive inputs for the next edge, then observe the cycle that follows.
    task automatic cycle(input logic s, input logic a);
        start = s;
        abort = a;
        model_edge(s, a);
        @(negedge clk);
        cyc++;
        check_outputs();
        array_step();
        if (m_t == T_DONE) check_products();
    endtask

    initial begin
        int prev_done;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        randomize_next();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single job from a start pulse.
        cycle(1'b1, 1'b0);
        repeat (30) cycle(1'b0, 1'b0);

        // Abort sampled at edge 10 of a job.
        cycle(1'b1, 1'b0);
        repeat (9) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0);

        // Start pulses inside a job are ignored, then a normal job follows.
        cycle(1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) cycle(k == 5 || k == 20, 1'b0);
        cycle(1'b1, 1'b0);
        repeat (30) cycle(1'b0, 1'b0);

        // Start and abort together in IDLE.
        repeat (3) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);

        // Back-to-back jobs with start held high.
        prev_done = -1;
        repeat (SPACING * 12) begin
            cycle(1'b1, 1'b0);
            if (done) begin
                if (prev_done >= 0) check("done_spacing", 32'(cyc - prev_done), 32'(SPACING));
                prev_done = cyc;
            end
        end
        repeat (30) cycle(1'b0, 1'b0);

        // Random starts and occasional aborts.
        repeat (2000) cycle($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Reset dropped while the job is in DRAIN.
        cycle(1'b1, 1'b0);
        repeat (19) cycle(1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // A clean job after reset.
        cycle(1'b1, 1'b0);
        repeat (30) cycle(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
